// File: rtl/mem_arb2.sv
// Two-port round-robin arbiter sharing one line-refill memory port between two cache controllers.
// Optional watchdog abort of stalled bursts is built when ARB_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | no owner; a request on any port is granted at the next edge
// BUSY    | burst in progress for the granted port, words counted on ack_mem2arb
// RELEASE | one dead cycle with grant dropped before the next arbitration
module mem_arb2 #(
    parameter int ADR_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WORD_OFFSET = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_cc2arb0,
    input  logic                  req_cc2arb1,
    input  logic [ADR_WIDTH-1:0]  adr_cc2arb0,
    input  logic [ADR_WIDTH-1:0]  adr_cc2arb1,
    output logic                  ack_arb2cc0,
    output logic                  ack_arb2cc1,
    output logic [DATA_WIDTH-1:0] dat_arb2cc,
    output logic                  req_arb2mem,
    output logic [ADR_WIDTH-1:0]  adr_arb2mem,
    input  logic                  ack_mem2arb,
    input  logic [DATA_WIDTH-1:0] dat_mem2arb,
    output logic [1:0]            gnt,
    output logic                  busy,
    output logic                  err_timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [1:0]             r_gnt, w_gnt_nxt;
    logic [WORD_OFFSET-1:0] r_cnt, w_cnt_nxt;
    logic                   r_ptr, w_ptr_nxt;
    logic                   w_busy;
    logic                   w_gidx;
    logic                   w_greq;
    logic                   w_last_ack;

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wdog, w_wdog_nxt;
    logic            r_err, w_err_nxt;
`endif

    assign w_busy     = (r_state == BUSY);
    assign w_gidx     = r_gnt[1];
    assign w_greq     = w_gidx ? req_cc2arb1 : req_cc2arb0;
    assign w_last_ack = ack_mem2arb && (r_cnt == '1);

    assign busy        = w_busy;
    assign gnt         = r_gnt;
    assign req_arb2mem = w_busy & w_greq;
    assign adr_arb2mem = w_busy ? (w_gidx ? adr_cc2arb1 : adr_cc2arb0) : '0;
    assign ack_arb2cc0 = ack_mem2arb & r_gnt[0] & w_busy;
    assign ack_arb2cc1 = ack_mem2arb & r_gnt[1] & w_busy;
    assign dat_arb2cc  = dat_mem2arb;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_ptr   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            r_wdog  <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
`ifdef ARB_TIMEOUT_EN
            r_wdog  <= w_wdog_nxt;
            r_err   <= w_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
`ifdef ARB_TIMEOUT_EN
        w_wdog_nxt  = '0;
        w_err_nxt   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                // Port 0 wins alone, or on a tie when port 1 was served last.
                if (req_cc2arb0 || req_cc2arb1) begin
                    w_state_nxt = BUSY;
                    w_gnt_nxt   = (req_cc2arb0 && (!req_cc2arb1 || r_ptr)) ? 2'b01 : 2'b10;
                end
            end
            BUSY: begin
                if (w_last_ack || !w_greq) begin
                    w_state_nxt = RELEASE;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = w_gidx;
                end else if (ack_mem2arb) begin
                    w_cnt_nxt = r_cnt + WORD_OFFSET'(1);
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                    w_state_nxt = RELEASE;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = w_gidx;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_wdog_nxt = r_wdog + WD_W'(1);
                end
`endif
            end
            RELEASE: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    assign err_timeout = r_err;
`else
    // No watchdog in this build; the limit parameter is intentionally left unused.
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT;
    assign err_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arb2.sv
// Self-checking bench for mem_arb2: directed scenarios plus random traffic,
// compared every cycle against a transaction-level reference model.
module tb_mem_arb2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WO = 2;
    localparam int TO = 64;
    localparam int NW = 1 << WO;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_cc2arb0, req_cc2arb1;
    logic [AW-1:0] adr_cc2arb0, adr_cc2arb1;
    logic          ack_arb2cc0, ack_arb2cc1;
    logic [DW-1:0] dat_arb2cc;
    logic          req_arb2mem;
    logic [AW-1:0] adr_arb2mem;
    logic          ack_mem2arb;
    logic [DW-1:0] dat_mem2arb;
    logic [1:0]    gnt;
    logic          busy;
    logic          err_timeout;

    mem_arb2 #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_OFFSET(WO), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_cc2arb0 (req_cc2arb0),
        .req_cc2arb1 (req_cc2arb1),
        .adr_cc2arb0 (adr_cc2arb0),
        .adr_cc2arb1 (adr_cc2arb1),
        .ack_arb2cc0 (ack_arb2cc0),
        .ack_arb2cc1 (ack_arb2cc1),
        .dat_arb2cc  (dat_arb2cc),
        .req_arb2mem (req_arb2mem),
        .adr_arb2mem (adr_arb2mem),
        .ack_mem2arb (ack_mem2arb),
        .dat_mem2arb (dat_mem2arb),
        .gnt         (gnt),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: who owns the memory port, how many words delivered so far,
    // and whether we are in the one-cycle gap after a burst.
    int m_phase;   // 0 free, 1 serving, 2 gap
    int m_owner;
    int m_words;
    int m_last;
    int m_stall;
    bit m_err;

    function automatic bit req_of(input int i);
        return (i == 1) ? req_cc2arb1 : req_cc2arb0;
    endfunction

    function automatic logic [AW-1:0] adr_of(input int i);
        return (i == 1) ? adr_cc2arb1 : adr_cc2arb0;
    endfunction

    task automatic model_edge();
        bit done;
        if (!rst) begin
            m_phase = 0; m_words = 0; m_last = 1; m_stall = 0; m_err = 0;
            return;
        end
        m_err = 0;
        case (m_phase)
            0: if (req_cc2arb0 || req_cc2arb1) begin
                   if (req_cc2arb0 && req_cc2arb1) m_owner = 1 - m_last;
                   else                            m_owner = req_cc2arb1 ? 1 : 0;
                   m_phase = 1; m_words = 0; m_stall = 0;
               end
            1: begin
                   done = 0;
                   if (ack_mem2arb) begin m_words++; m_stall = 0; end
                   else             m_stall++;
                   if (m_words == NW)           done = 1;
                   else if (!req_of(m_owner))   done = 1;
`ifdef ARB_TIMEOUT_EN
                   else if (m_stall == TO) begin done = 1; m_err = 1; end
`endif
                   if (done) begin m_phase = 2; m_last = m_owner; m_words = 0; end
               end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_outputs();
        bit serving;
        serving = (m_phase == 1);
        check("gnt",     gnt,         serving ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00);
        check("busy",    busy,        serving);
        check("req_mem", req_arb2mem, serving && req_of(m_owner));
        check("adr_mem", adr_arb2mem, serving ? adr_of(m_owner) : '0);
        check("ack0",    ack_arb2cc0, ack_mem2arb && serving && m_owner == 0);
        check("ack1",    ack_arb2cc1, ack_mem2arb && serving && m_owner == 1);
        check("dat",     dat_arb2cc,  dat_mem2arb);
        check("err",     err_timeout, m_err);
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    int err_seen;
    int ack_pct;
    int tog;

    initial begin
        rst = 1'b0;
        req_cc2arb0 = 0; req_cc2arb1 = 0;
        adr_cc2arb0 = '0; adr_cc2arb1 = '0;
        ack_mem2arb = 0; dat_mem2arb = '0;
        @(posedge clk);
        model_edge();
        #1;
        check("rst_gnt",  gnt, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_err",  err_timeout, 1'b0);
        rst = 1'b1;
        step();

        // Controller 0 alone, four data words.
        req_cc2arb0 = 1; adr_cc2arb0 = 32'hFF07BD08;
        step();
        check("c0_gnt", gnt, 2'b01);
        check("c0_adr", adr_arb2mem, 32'hFF07BD08);
        for (int i = 0; i < NW; i++) begin
            ack_mem2arb = 1; dat_mem2arb = 32'hF54CD4A5 - 32'(i) * 32'h00040000;
            #1;
            check("c0_ack", ack_arb2cc0, 1'b1);
            check("c0_dat", dat_arb2cc, 32'hF54CD4A5 - 32'(i) * 32'h00040000);
            step();
        end
        ack_mem2arb = 0; req_cc2arb0 = 0;
        check("c0_rel_gnt",  gnt, 2'b00);
        check("c0_rel_busy", busy, 1'b0);
        step();
        step();

        // Tie after reset: controller 0 first, then controller 1.
        rst = 0; step(); rst = 1;
        req_cc2arb0 = 1; req_cc2arb1 = 1; adr_cc2arb1 = 32'h158AAD08;
        step();
        check("tie_gnt0", gnt, 2'b01);
        for (int i = 0; i < NW; i++) begin
            ack_mem2arb = 1; dat_mem2arb = $urandom;
            #1;
            check("tie_ack1_held", ack_arb2cc1, 1'b0);
            step();
        end
        ack_mem2arb = 0;
        step();
        step();
        check("tie_gnt1", gnt, 2'b10);
        check("tie_adr1", adr_arb2mem, 32'h158AAD08);

        // Controller 1 finishes, both still requesting: round-robin back to 0.
        for (int i = 0; i < NW; i++) begin
            ack_mem2arb = 1; dat_mem2arb = $urandom;
            step();
        end
        ack_mem2arb = 0;
        step();
        step();
        check("rr_gnt0", gnt, 2'b01);
        for (int i = 0; i < NW; i++) begin
            ack_mem2arb = 1; dat_mem2arb = $urandom;
            #1;
            check("rr_ack1_held", ack_arb2cc1, 1'b0);
            step();
        end
        ack_mem2arb = 0; req_cc2arb0 = 0; req_cc2arb1 = 0;
        step();
        step();

        // Abort after two words, then a complete burst.
        req_cc2arb0 = 1;
        step();
        for (int i = 0; i < 2; i++) begin ack_mem2arb = 1; step(); end
        ack_mem2arb = 0; req_cc2arb0 = 0;
        step();
        check("abort_gnt",  gnt, 2'b00);
        check("abort_busy", busy, 1'b0);
        req_cc2arb0 = 1;
        step();
        step();
        check("after_abort_gnt", gnt, 2'b01);
        for (int i = 0; i < NW; i++) begin ack_mem2arb = 1; step(); end
        ack_mem2arb = 0; req_cc2arb0 = 0;
        check("after_abort_done", busy, 1'b0);
        step();
        step();

        // Reset in the cycle after the third ack.
        req_cc2arb0 = 1;
        step();
        for (int i = 0; i < 3; i++) begin ack_mem2arb = 1; step(); end
        ack_mem2arb = 0; rst = 0;
        step();
        check("rst_mid_req", req_arb2mem, 1'b0);
        check("rst_mid_gnt", gnt, 2'b00);
        rst = 1; ack_mem2arb = 1;
        #1;
        check("rst_stray_ack", ack_arb2cc0, 1'b0);
        step();
        ack_mem2arb = 0; req_cc2arb0 = 0;
        step(); step(); step();

        // Stalled burst: no acks at all.
        err_seen = 0;
        req_cc2arb0 = 1;
        for (int i = 0; i < TO + 6; i++) begin
            step();
            if (err_timeout === 1'b1) err_seen++;
        end
`ifdef ARB_TIMEOUT_EN
        check("wd_err_pulses", 32'(err_seen), 32'd1);
`else
        check("wd_err_pulses", 32'(err_seen), 32'd0);
        check("wd_busy_holds", busy, 1'b1);
`endif
        req_cc2arb0 = 0;
        step(); step(); step();

        // Random traffic.
        ack_pct = 50; tog = 8;
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) begin
                ack_pct = (ack_pct == 50) ? 0 : 50;
                tog     = (ack_pct == 0) ? 128 : 8;
            end
            if ($urandom_range(0, tog - 1) == 0) begin
                req_cc2arb0 = ~req_cc2arb0; adr_cc2arb0 = $urandom;
            end
            if ($urandom_range(0, tog - 1) == 0) begin
                req_cc2arb1 = ~req_cc2arb1; adr_cc2arb1 = $urandom;
            end
            ack_mem2arb = ($urandom_range(0, 99) < ack_pct);
            dat_mem2arb = $urandom;
            rst = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
